bluetooth_cmd_streamer: RTL

Parametrised successor to the fixed 144-bit Bluetooth AT-command encoder. Builds AT command frames for the BLE UART module and emits them one ASCII byte per handshake on a valid/ready byte stream, feeding the UART TX path directly. Payloads are variable-length, up to MAX_PAYLOAD bytes. Adds a ping command, length checking and an error response.

---
 rtl/bluetooth_pkg.sv | 42 ++++
 rtl/bluetooth_prefix_rom.sv | 31 +++
 rtl/bluetooth_cmd_streamer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/bluetooth_pkg.sv
// rtl/bluetooth_pkg.sv - shared constants and helpers for the BLE AT-command streamer
package bluetooth_pkg;

    localparam logic [7:0] ASCII_A    = 8'h41;
    localparam logic [7:0] ASCII_B    = 8'h42;
    localparam logic [7:0] ASCII_E    = 8'h45;
    localparam logic [7:0] ASCII_L    = 8'h4C;
    localparam logic [7:0] ASCII_R    = 8'h52;
    localparam logic [7:0] ASCII_T    = 8'h54;
    localparam logic [7:0] ASCII_U    = 8'h55;
    localparam logic [7:0] ASCII_X    = 8'h58;
    localparam logic [7:0] ASCII_PLUS = 8'h2B;
    localparam logic [7:0] ASCII_EQ   = 8'h3D;
    localparam logic [7:0] ASCII_CR   = 8'h0D;

    localparam logic [3:0] CMD_TX   = 4'd1;
    localparam logic [3:0] CMD_RX   = 4'd2;
    localparam logic [3:0] CMD_PING = 4'd3;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_PREFIX  = 2'd1;
    localparam state_t ST_PAYLOAD = 2'd2;
    localparam state_t ST_TERM    = 2'd3;

    localparam int PREFIX_LEN_TX   = 13;
    localparam int PREFIX_LEN_RX   = 12;
    localparam int PREFIX_LEN_PING = 2;

    function automatic logic cmd_valid(input logic [3:0] cmd);
        return (cmd == CMD_TX) || (cmd == CMD_RX) || (cmd == CMD_PING);
    endfunction

    function automatic logic [3:0] prefix_last(input logic [3:0] cmd);
        case (cmd)
            CMD_TX:  return 4'(PREFIX_LEN_TX - 1);
            CMD_RX:  return 4'(PREFIX_LEN_RX - 1);
            default: return 4'(PREFIX_LEN_PING - 1);
        endcase
    endfunction

endpackage

// File: rtl/bluetooth_prefix_rom.sv
// rtl/bluetooth_prefix_rom.sv - constant AT prefix text indexed by command and position
module bluetooth_prefix_rom
    import bluetooth_pkg::*;
(
    input  logic [3:0] cmd_i,
    input  logic [3:0] index_i,
    output logic [7:0] byte_o
);

    // TX and RX prefixes share every character except position 10; PING uses only 0..1.
    always_comb begin
        byte_o = 8'h00;
        case (index_i)
            4'd0:    byte_o = ASCII_A;
            4'd1:    byte_o = ASCII_T;
            4'd2:    byte_o = ASCII_PLUS;
            4'd3:    byte_o = ASCII_B;
            4'd4:    byte_o = ASCII_L;
            4'd5:    byte_o = ASCII_E;
            4'd6:    byte_o = ASCII_U;
            4'd7:    byte_o = ASCII_A;
            4'd8:    byte_o = ASCII_R;
            4'd9:    byte_o = ASCII_T;
            4'd10:   byte_o = (cmd_i == CMD_TX) ? ASCII_T : ASCII_R;
            4'd11:   byte_o = ASCII_X;
            4'd12:   byte_o = ASCII_EQ;
            default: byte_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/bluetooth_cmd_streamer.sv
// rtl/bluetooth_cmd_streamer.sv - AT command frame builder emitting one byte per handshake
module bluetooth_cmd_streamer
    import bluetooth_pkg::*;
#(
    parameter int MAX_PAYLOAD = 16,
    parameter int LEN_W       = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [3:0]               command_select,
    input  logic [8*MAX_PAYLOAD-1:0] payload_data,
    input  logic [LEN_W-1:0]         payload_len,
    output logic [7:0]               out_byte,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    state_t                   state_q, state_d;
    logic [3:0]               cmd_q, cmd_d;
    logic [8*MAX_PAYLOAD-1:0] payload_q, payload_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [LEN_W-1:0]         pcnt_q, pcnt_d;
    logic [3:0]               pidx_q, pidx_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic [7:0]               rom_byte;
    logic [7:0]               payload_byte;
    logic                     start_bad;

    bluetooth_prefix_rom u_prefix_rom (
        .cmd_i   (cmd_q),
        .index_i (pidx_q),
        .byte_o  (rom_byte)
    );

    assign payload_byte = payload_q[{pcnt_q, 3'b000} +: 8];
    assign start_bad    = !cmd_valid(command_select) ||
                          ((command_select == CMD_TX) && (payload_len > LEN_W'(MAX_PAYLOAD)));

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        payload_d = payload_q;
        len_d     = len_q;
        pcnt_d    = pcnt_q;
        pidx_d    = pidx_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (start_bad) begin
                        error_d = 1'b1;
                    end else begin
                        cmd_d     = command_select;
                        payload_d = payload_data;
                        len_d     = payload_len;
                        pidx_d    = 4'd0;
                        pcnt_d    = '0;
                        state_d   = ST_PREFIX;
                    end
                end
            end
            ST_PREFIX: begin
                if (out_ready) begin
                    if (pidx_q == prefix_last(cmd_q)) begin
                        state_d = ((cmd_q == CMD_TX) && (len_q != '0)) ? ST_PAYLOAD : ST_TERM;
                    end else begin
                        pidx_d = pidx_q + 4'd1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (out_ready) begin
                    if (pcnt_q == len_q - LEN_W'(1)) begin
                        state_d = ST_TERM;
                    end else begin
                        pcnt_d = pcnt_q + LEN_W'(1);
                    end
                end
            end
            default: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    pidx_d  = 4'd0;
                    pcnt_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cmd_q     <= 4'd0;
            payload_q <= '0;
            len_q     <= '0;
            pcnt_q    <= '0;
            pidx_q    <= 4'd0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            payload_q <= payload_d;
            len_q     <= len_d;
            pcnt_q    <= pcnt_d;
            pidx_q    <= pidx_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // Output byte is a pure function of registered state, so it cannot move during a stall.
    always_comb begin
        out_byte = 8'h00;
        case (state_q)
            ST_PREFIX:  out_byte = rom_byte;
            ST_PAYLOAD: out_byte = payload_byte;
            ST_TERM:    out_byte = ASCII_CR;
            default:    out_byte = 8'h00;
        endcase
    end

    assign out_valid = (state_q != ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign error     = error_q;

endmodule
